// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time over valid/ready, fixed LATENCY.
// Optional misaligned-access error reporting is enabled with `define DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        resp_err
`endif
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic [31:0]           mem_q [DEPTH];
    logic                  mem_we;
    logic                  req_fire;
    logic                  misalign;
    logic                  unused_addr_bits;

`ifdef DMEM_MISALIGN_ERR_EN
    logic [1:0]            lo_q, lo_d;
    logic                  resp_err_q, resp_err_d;
    assign misalign = (lo_q != 2'b00);
    assign resp_err = resp_err_q;
`else
    assign misalign = 1'b0;
`endif

    assign unused_addr_bits = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};

    // A new request may be taken in RESP only on the same edge the response retires.
    assign req_ready  = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    assign req_fire   = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        mem_we       = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        lo_d         = lo_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    mem_we       = write_q && !misalign;
                    resp_rdata_d = (write_q || misalign) ? 32'd0 : mem_q[idx_q];
`ifdef DMEM_MISALIGN_ERR_EN
                    resp_err_d   = misalign;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
                    resp_err_d   = 1'b0;
`endif
                end
            end
            default: ;
        endcase
        if (req_fire) begin
            state_d = BUSY;
            cnt_d   = 8'(LATENCY - 1);
            write_d = req_write;
            idx_d   = req_addr[ADDR_BITS+1:2];
            wdata_d = req_wdata;
`ifdef DMEM_MISALIGN_ERR_EN
            lo_d    = req_addr[1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
            lo_q         <= 2'b00;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef DMEM_MISALIGN_ERR_EN
            lo_q         <= lo_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    // Every word clears on reset, so each one is its own resettable register.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q[gi] <= 32'd0;
            end else if (mem_we && (idx_q == ADDR_BITS'(gi))) begin
                mem_q[gi] <= wdata_q;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: main instance at LATENCY=2, second at LATENCY=1.
module tb_dmem_responder;
    localparam int LAT = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        f_req_valid, f_req_ready, f_req_write, f_resp_valid, f_resp_ready;
    logic [31:0] f_req_addr, f_req_wdata, f_resp_rdata;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        resp_err, f_resp_err;
`endif

    int  n_asserts = 0;
    int  n_fail    = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(LAT), .ADDR_BITS(10)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
`ifdef DMEM_MISALIGN_ERR_EN
        , .resp_err(resp_err)
`endif
    );

    dmem_responder #(.LATENCY(1), .ADDR_BITS(10)) u_fast (
        .clk(clk), .reset(reset),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .resp_valid(f_resp_valid), .resp_ready(f_resp_ready), .resp_rdata(f_resp_rdata)
`ifdef DMEM_MISALIGN_ERR_EN
        , .resp_err(f_resp_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, wait for acceptance, push the expected response.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input sb_t e);
        int k;
        k = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_in_time", 32'(k < 40), 32'd1);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called one negedge after the accept edge; resp_valid must first appear LAT+1 negedges after it.
    task automatic wait_resp(input string tag);
        int k;
        k = 1;
        while (resp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k), 32'(LAT + 1));
    endtask

    task automatic take_resp(input int hold);
        sb_t e;
        e = sb_q.pop_front();
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_rdata", resp_rdata, e.rdata);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", resp_rdata, e.rdata);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("resp_err", 32'(resp_err), 32'(e.err));
`endif
        resp_ready = 1'b1;
        #1;
        chk("req_ready_follows_resp_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_retired", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        f_req_valid = 1'b0; f_req_write = 1'b0; f_req_addr = 32'd0; f_req_wdata = 32'd0; f_resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        // Store then load, with 5 cycles of backpressure on the load response.
        send(1'b1, 32'h40, 32'hDEADBEEF, '{32'd0, 1'b0});
        wait_resp("store_latency");
        take_resp(0);
        send(1'b0, 32'h40, 32'd0, '{32'hDEADBEEF, 1'b0});
        wait_resp("load_latency");
        take_resp(5);

`ifdef DMEM_MISALIGN_ERR_EN
        send(1'b1, 32'h42, 32'h55555555, '{32'd0, 1'b1});
        wait_resp("misalign_store_latency");
        take_resp(0);
        send(1'b0, 32'h40, 32'd0, '{32'hDEADBEEF, 1'b0});
        wait_resp("aligned_load_latency");
        take_resp(0);
`endif

        // Address bits above the word index are ignored, so 0x1000 aliases 0x0.
        send(1'b1, 32'h0, 32'h1, '{32'd0, 1'b0});
        wait_resp("wrap_store0_latency");
        take_resp(0);
        send(1'b1, 32'h1000, 32'h2, '{32'd0, 1'b0});
        wait_resp("wrap_store1_latency");
        take_resp(0);
        send(1'b0, 32'h0, 32'd0, '{32'h2, 1'b0});
        wait_resp("wrap_load_latency");
        take_resp(1);

        // Reset while a store sits in BUSY: it must never commit.
        send(1'b1, 32'h80, 32'h12345678, '{32'd0, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_rdata", resp_rdata, 32'd0);
        send(1'b0, 32'h80, 32'd0, '{32'd0, 1'b0});
        wait_resp("midrst_load_latency");
        take_resp(0);
        send(1'b0, 32'h40, 32'd0, '{32'd0, 1'b0});
        wait_resp("cleared_load_latency");
        take_resp(0);

        // LATENCY=1 with req_valid held and resp_ready high: one transaction every 2 cycles.
        f_resp_ready = 1'b1;
        f_req_addr   = 32'h10;
        f_req_wdata  = 32'hA5A5A5A5;
        f_req_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f_req_write = (i == 0);
            chk("fast_req_ready", 32'(f_req_ready), 32'(i % 2 == 0));
            chk("fast_resp_valid", 32'(f_resp_valid), 32'((i > 0) && (i % 2 == 0)));
            if ((i > 0) && (i % 2 == 0))
                chk("fast_resp_rdata", f_resp_rdata, (i == 2) ? 32'd0 : 32'hA5A5A5A5);
            @(negedge clk);
        end
        f_req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
